// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory request channel.
// Used by the MEM-stage initiator and the data-memory responder.
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } mem_state_e;

   localparam int MEM_IDX_W  = 11;
   localparam int MEM_DATA_W = 32;

   // Word index is taken above the byte-offset bits.
   localparam int IDX_LSB = 2;

   function automatic int idx_msb(input int idx_w);
      return idx_w + IDX_LSB - 1;
   endfunction

endpackage

// File: rtl/mem_req_initiator.sv
// MEM-stage data-memory initiator: turns load/store strobes into one
// valid/ready request, collects read data and freezes the pipeline.
module mem_req_initiator
   import mem_if_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = MEM_DATA_W,
   parameter int IDX_W  = MEM_IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [ADDR_W-1:0] ALU_Res,
   input  logic [DATA_W-1:0] Val_Rm,
   output logic              freeze,
   output logic [DATA_W-1:0] MEM_Result,
   output logic              mem_req_valid,
   output logic              mem_req_we,
   output logic [IDX_W-1:0]  mem_req_idx,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata
);

   localparam int IDX_HI = idx_msb(IDX_W);

   mem_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] result_q, result_d;

   logic [IDX_W-1:0]  addr_idx;
   logic              unused_addr_bits;

   // Offset and high address bits fall away, so the index wraps.
   assign addr_idx = ALU_Res[IDX_HI:IDX_LSB];
   assign unused_addr_bits = ^{ALU_Res[ADDR_W-1:IDX_HI+1],
                               ALU_Res[IDX_LSB-1:0]};

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      idx_d         = idx_q;
      wdata_d       = wdata_q;
      result_d      = result_q;
      freeze        = 1'b0;
      mem_req_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (MEM_W_EN || MEM_R_EN) begin
               freeze  = 1'b1;
               we_d    = MEM_W_EN;
               idx_d   = addr_idx;
               wdata_d = Val_Rm;
               state_d = REQ;
            end
         end
         REQ: begin
            freeze        = 1'b1;
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = we_q ? DONE : WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            freeze = 1'b1;
            if (mem_rsp_valid) begin
               result_d = mem_rsp_rdata;
               state_d  = DONE;
            end
         end
         // One unfrozen cycle; the instruction still present is not re-issued.
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         result_q <= result_d;
      end
   end

   assign mem_req_we    = we_q;
   assign mem_req_idx   = idx_q;
   assign mem_req_wdata = wdata_q;
   assign MEM_Result    = result_q;

endmodule

// File: doc/mem_req_initiator.md
# mem_req_initiator

Initiator side of the data-memory request channel for the MEM stage. Turns the MEM stage's single-cycle load/store strobes into a valid/ready request to a multi-cycle data-memory responder. It collects read data from a response channel and freezes the upstream pipeline until each access completes. It sits between the EX/MEM pipeline register and the shared data-memory responder.

## Interface
- ADDR_W, 32, width of byte address from ALU
- DATA_W, 32, data word width
- IDX_W, 11, word-index width sent to memory (word index = ALU_Res[IDX_W+1:2])
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- MEM_R_EN  in  1  load requested by instruction in MEM
- MEM_W_EN  in  1  store requested by instruction in MEM
- ALU_Res  in  ADDR_W  byte address
- Val_Rm  in  DATA_W  store data
- freeze  out  1  stall EX/MEM and earlier stages while high
- MEM_Result  out  DATA_W  last load data, registered
- mem_req_valid  out  1  request valid
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_idx  out  IDX_W  word index
- mem_req_wdata  out  DATA_W  write data
- mem_req_ready  in  1  responder accepts request
- mem_rsp_valid  in  1  read data valid, one-cycle pulse
- mem_rsp_rdata  in  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - If MEM_W_EN or MEM_R_EN, capture we/idx/wdata into payload registers and go to REQ.
  - MEM_W_EN has priority. Both high is a write; the read is dropped.
- REQ:
  - mem_req_valid=1 with payload held stable.
  - On mem_req_ready: write goes to DONE, since writes complete on acceptance. Read goes to WAIT_RSP.
  - Without ready, stay in REQ. Payload must not change.
- WAIT_RSP: on mem_rsp_valid, load MEM_Result <= mem_rsp_rdata and go to DONE. mem_rsp_valid in any other state is ignored.
- DONE:
  - freeze=0 for exactly one cycle so the pipeline captures MEM_Result and advances.
  - Inputs are ignored, so the same instruction still present is not re-issued.
  - Unconditionally returns to IDLE.
- freeze = (IDLE & (MEM_R_EN | MEM_W_EN)) | REQ | WAIT_RSP. It is combinational, so the stall begins in the detect cycle.
- MEM_Result holds its value across writes and idle cycles; it changes only on a read response.
- Width rule: mem_req_idx = ALU_Res[IDX_W+1:2]. Byte-offset bits [1:0] and bits above IDX_W+1 are discarded, so the index wraps modulo 2^IDX_W.
- Reset:
  - Asynchronous, usable mid-transaction.
  - Forces IDLE, freeze=0 (inputs deasserted), mem_req_valid=0, mem_req_we=0, mem_req_idx=0, mem_req_wdata=0, MEM_Result=0.
  - An outstanding read is abandoned. The responder shares rst_n.

## Timing
- A responder with ready tied high and response one cycle after acceptance gives:
  - Read: detect in C0 (IDLE), accept in C1 (REQ), rsp_valid in C2 (WAIT_RSP), DONE in C3. freeze is high for C0–C2; MEM_Result is valid from C3.
  - Write: detect in C0, accept in C1, DONE in C2. freeze is high for C0–C1.
- Each cycle of ready low adds one freeze cycle. Each extra response-wait cycle adds one.
- The responder must not assert mem_rsp_valid in the acceptance cycle; minimum read latency is one cycle after acceptance.
- At most one transaction is outstanding. No pipelining of requests.
- Back-to-back accesses: the next instruction is detected the cycle after DONE. The minimum gap is one non-frozen cycle per access.

## Structure
- Shared package mem_if_pkg holds:
  - the state enum (IDLE, REQ, WAIT_RSP, DONE)
  - IDX_W and DATA_W defaults
  - the word-index slice constants, also used by the responder
- Single module; no sub-module is warranted. The FSM and payload registers fit in one block of roughly 150 lines.

## Test plan
- Read with zero-wait responder: store image word 5 = 0xDEADBEEF, MEM_R_EN=1, ALU_Res=0x14 -> mem_req_idx=5, mem_req_we=0, freeze high 3 cycles, MEM_Result=0xDEADBEEF in DONE.
- Write with ready held low 4 cycles: MEM_W_EN=1, ALU_Res=0x2000_0008, Val_Rm=0x12345678 -> mem_req_idx=2 (wrap), valid and payload stable all 4 cycles, freeze high 6 cycles total, MEM_Result unchanged.
- Simultaneous MEM_R_EN=1 and MEM_W_EN=1 -> one write only, mem_req_we=1, no response expected, returns to IDLE.
- No re-issue: hold MEM_R_EN=1 through DONE -> exactly one request per access; a second request is issued only after IDLE re-detects.
- Reset in WAIT_RSP: assert rst_n=0 for one cycle, then pulse mem_rsp_valid -> all outputs 0, pulse ignored, MEM_Result stays 0.
- Stray mem_rsp_valid with data 0xFFFFFFFF in IDLE -> MEM_Result unchanged, freeze stays 0.
